hazard_ctrl: RTL and testbench

Second-generation pipeline hazard controller for the 5-stage core. It sits beside the EX/MEM/WB pipeline registers and does four things:
- Selects the operand forwarding source for EX.
- Generates load-use bubbles and branch flushes.
- Stalls the whole pipeline while a variable-latency data-memory load waits for `mem_ready`. A timeout aborts the wait if it never comes.
- Keeps saturating stall/flush performance counters.

A parameter selects full forwarding or pure interlock mode.

---
 rtl/otter_pkg.sv | 49 ++++
 rtl/hazard_match.sv | 26 ++
 rtl/hazard_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared types for the 5-stage core: opcodes, decoded instruction bundle
// and the EX operand forwarding select.
package otter_pkg;

   typedef enum logic [6:0] {
      LUI    = 7'b0110111,
      AUIPC  = 7'b0010111,
      JAL    = 7'b1101111,
      JALR   = 7'b1100111,
      BRANCH = 7'b1100011,
      LOAD   = 7'b0000011,
      STORE  = 7'b0100011,
      OP_IMM = 7'b0010011,
      OP     = 7'b0110011,
      SYSTEM = 7'b1110011
   } opcode_t;

   typedef struct packed {
      opcode_t    opcode;
      logic [4:0] rs1_addr;
      logic       rs1_used;
      logic [4:0] rs2_addr;
      logic       rs2_used;
      logic [4:0] rd_addr;
      logic       regWrite;
      logic       memRead2;
   } instr_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   // A load in MEM has no data yet, so it can only be forwarded once it reaches WB.
   function automatic fwd_sel_t fwd_pick(input logic hit_mem, input logic is_ld,
                                         input logic hit_wb);
      fwd_sel_t sel;
      if (hit_mem && !is_ld) begin
         sel = FWD_MEM;
      end else if (hit_wb) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source RAW comparator: does the EX source register match a pending
// write in MEM or WB? x0 never matches.
module hazard_match
   import otter_pkg::*;
(
   input  logic [4:0] src_addr,
   input  logic       src_used,
   input  instr_t     mem_i,
   input  instr_t     wb_i,
   output logic       hit_mem,
   output logic       hit_wb
);

   logic src_live;
   logic unused_fields;

   assign src_live = src_used && (src_addr != 5'd0);
   assign hit_mem  = src_live && mem_i.regWrite && (src_addr == mem_i.rd_addr);
   assign hit_wb   = src_live && wb_i.regWrite && (src_addr == wb_i.rd_addr);

   assign unused_fields = ^{mem_i.opcode, mem_i.rs1_addr, mem_i.rs1_used, mem_i.rs2_addr,
                            mem_i.rs2_used, mem_i.memRead2,
                            wb_i.opcode, wb_i.rs1_addr, wb_i.rs1_used, wb_i.rs2_addr,
                            wb_i.rs2_used, wb_i.memRead2};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use bubbles, branch
// flushes, bounded memory-wait stall with timeout, and saturating perf counters.
module hazard_ctrl
   import otter_pkg::*;
#(
   parameter int FWD_EN   = 1,
   parameter int MAX_WAIT = 16,
   parameter int WAIT_W   = $clog2(MAX_WAIT + 1),
   parameter int CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  instr_t           ex,
   input  instr_t           mem,
   input  instr_t           wb,
   input  logic             br_taken,
   input  logic             mem_ready,
   input  logic             clr_cnt,
   output fwd_sel_t         fwd_sel1,
   output fwd_sel_t         fwd_sel2,
   output logic             stall_if,
   output logic             stall_dec,
   output logic             stall_ex,
   output logic             stall_mem,
   output logic             flush_dec,
   output logic             flush_ex,
   output logic             flush_mem,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;
   logic [CNT_W-1:0]  flush_count_q, flush_count_d;

   logic h1_mem, h1_wb, h2_mem, h2_wb;
   logic is_ld, wait_req, lu_haz, wait_expired;
   logic stall_all, resolve;
   logic unused_ex;

   hazard_match u_match1 (
      .src_addr (ex.rs1_addr),
      .src_used (ex.rs1_used),
      .mem_i    (mem),
      .wb_i     (wb),
      .hit_mem  (h1_mem),
      .hit_wb   (h1_wb)
   );

   hazard_match u_match2 (
      .src_addr (ex.rs2_addr),
      .src_used (ex.rs2_used),
      .mem_i    (mem),
      .wb_i     (wb),
      .hit_mem  (h2_mem),
      .hit_wb   (h2_wb)
   );

   assign is_ld        = (mem.opcode == LOAD);
   assign wait_req     = is_ld && mem.memRead2 && !mem_ready;
   assign lu_haz       = (FWD_EN != 0) ? (is_ld && (h1_mem || h2_mem))
                                       : (h1_mem || h2_mem || h1_wb || h2_wb);
   assign wait_expired = (wait_cnt_q == WAIT_W'(MAX_WAIT));
   assign unused_ex    = ^{ex.opcode, ex.rd_addr, ex.regWrite, ex.memRead2};

   // State, wait counter, timeout pulse and perf counters
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= {WAIT_W{1'b0}};
         mem_timeout_q <= 1'b0;
         stall_count_q <= {CNT_W{1'b0}};
         flush_count_q <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   // Next-state logic for the memory-wait FSM
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (wait_req) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else begin
               wait_cnt_d = {WAIT_W{1'b0}};
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = {WAIT_W{1'b0}};
            end else if (wait_expired) begin
               state_d       = ST_RUN;
               wait_cnt_d    = {WAIT_W{1'b0}};
               mem_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = {WAIT_W{1'b0}};
         end
      endcase
   end

   // Mealy stall/flush/forward outputs; a stall always masks the branch redirect
   always_comb begin
      stall_all = 1'b0;
      resolve   = 1'b0;
      stall_if  = 1'b0;
      stall_dec = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      flush_dec = 1'b0;
      flush_ex  = 1'b0;
      flush_mem = 1'b0;
      fwd_sel1  = FWD_RF;
      fwd_sel2  = FWD_RF;
      case (state_q)
         ST_RUN: begin
            if (wait_req) begin
               stall_all = 1'b1;
            end else begin
               resolve = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready) begin
               resolve = 1'b1;
            end else if (!wait_expired) begin
               stall_all = 1'b1;
            end else begin
               stall_all = 1'b0;
            end
         end
         default: begin
            resolve = 1'b0;
         end
      endcase
      if (RST) begin
         stall_all = 1'b0;
         resolve   = 1'b0;
      end else begin
         if (FWD_EN != 0) begin
            fwd_sel1 = fwd_pick(h1_mem, is_ld, h1_wb);
            fwd_sel2 = fwd_pick(h2_mem, is_ld, h2_wb);
         end else begin
            fwd_sel1 = FWD_RF;
            fwd_sel2 = FWD_RF;
         end
      end
      if (stall_all) begin
         stall_if  = 1'b1;
         stall_dec = 1'b1;
         stall_ex  = 1'b1;
         stall_mem = 1'b1;
      end else if (resolve && lu_haz) begin
         stall_if  = 1'b1;
         stall_dec = 1'b1;
         stall_ex  = 1'b1;
         flush_mem = 1'b1;
      end else if (resolve && br_taken) begin
         flush_dec = 1'b1;
         flush_ex  = 1'b1;
      end else begin
         flush_mem = 1'b0;
      end
   end

   // Saturating perf counters; clear wins over increment
   always_comb begin
      if (clr_cnt) begin
         stall_count_d = {CNT_W{1'b0}};
         flush_count_d = {CNT_W{1'b0}};
      end else begin
         stall_count_d = stall_count_q;
         flush_count_d = flush_count_q;
         if (stall_if && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
         end else begin
            stall_count_d = stall_count_q;
         end
         if (flush_dec && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
         end else begin
            flush_count_d = flush_count_q;
         end
      end
   end

   assign mem_timeout = mem_timeout_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two hazard_ctrl instances (forwarding, small counters and
// short timeout; interlock mode) driven by directed then random stimulus.
module tb_hazard_ctrl;
   import otter_pkg::*;

   typedef struct packed {
      logic [1:0]  f1;
      logic [1:0]  f2;
      logic [3:0]  st;   // {if, dec, ex, mem}
      logic [2:0]  fl;   // {dec, ex, mem}
      logic        to;
      logic [15:0] sc;
      logic [15:0] fc;
   } obs_t;

   logic   CLK = 1'b0;
   logic   RST;
   instr_t ex, mem, wb;
   logic   br_taken, mem_ready, clr_cnt;

   always #5 CLK = ~CLK;

   logic [1:0]  a_f1, a_f2, b_f1, b_f2;
   logic        a_sif, a_sdec, a_sex, a_smem, a_fdec, a_fex, a_fmem, a_to;
   logic        b_sif, b_sdec, b_sex, b_smem, b_fdec, b_fex, b_fmem, b_to;
   logic [3:0]  a_sc, a_fc;
   logic [15:0] b_sc, b_fc;

   hazard_ctrl #(.FWD_EN(1), .MAX_WAIT(4), .CNT_W(4)) dut_a (
      .CLK(CLK), .RST(RST), .ex(ex), .mem(mem), .wb(wb), .br_taken(br_taken),
      .mem_ready(mem_ready), .clr_cnt(clr_cnt), .fwd_sel1(a_f1), .fwd_sel2(a_f2),
      .stall_if(a_sif), .stall_dec(a_sdec), .stall_ex(a_sex), .stall_mem(a_smem),
      .flush_dec(a_fdec), .flush_ex(a_fex), .flush_mem(a_fmem), .mem_timeout(a_to),
      .stall_count(a_sc), .flush_count(a_fc)
   );

   hazard_ctrl #(.FWD_EN(0), .MAX_WAIT(6), .CNT_W(16)) dut_b (
      .CLK(CLK), .RST(RST), .ex(ex), .mem(mem), .wb(wb), .br_taken(br_taken),
      .mem_ready(mem_ready), .clr_cnt(clr_cnt), .fwd_sel1(b_f1), .fwd_sel2(b_f2),
      .stall_if(b_sif), .stall_dec(b_sdec), .stall_ex(b_sex), .stall_mem(b_smem),
      .flush_dec(b_fdec), .flush_ex(b_fex), .flush_mem(b_fmem), .mem_timeout(b_to),
      .stall_count(b_sc), .flush_count(b_fc)
   );

   obs_t obs_a, obs_b;
   assign obs_a = '{a_f1, a_f2, {a_sif, a_sdec, a_sex, a_smem}, {a_fdec, a_fex, a_fmem},
                    a_to, {12'd0, a_sc}, {12'd0, a_fc}};
   assign obs_b = '{b_f1, b_f2, {b_sif, b_sdec, b_sex, b_smem}, {b_fdec, b_fex, b_fmem},
                    b_to, b_sc, b_fc};

   // Reference model: per instance, whether a memory wait is open, how many
   // stall cycles it has used, a pending timeout flag and the two counters.
   int p_fwd [2]  = '{1, 0};
   int p_maxw [2] = '{4, 6};
   int p_cmax [2] = '{15, 65535};
   bit m_wait [2], n_wait [2];
   int m_used [2], n_used [2];
   bit m_to [2], n_to [2];
   int m_sc [2], n_sc [2];
   int m_fc [2], n_fc [2];

   obs_t exp_a_q[$], exp_b_q[$];
   int n_cmp = 0;
   int n_fail = 0;

   function automatic bit hit(input logic [4:0] a, input logic u, input instr_t x);
      return u && (a != 5'd0) && (a == x.rd_addr) && x.regWrite;
   endfunction

   function automatic logic [1:0] pick(input bit use_fwd, input bit hm, input bit ld, input bit hw);
      if (!use_fwd) return 2'b00;
      if (hm && !ld) return 2'b01;
      if (hw) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_step(input int d, output obs_t e);
      bit ld, h1m, h1w, h2m, h2w, lu, req, free, hold;
      e = '0;
      ld  = (mem.opcode == LOAD);
      h1m = hit(ex.rs1_addr, ex.rs1_used, mem);
      h1w = hit(ex.rs1_addr, ex.rs1_used, wb);
      h2m = hit(ex.rs2_addr, ex.rs2_used, mem);
      h2w = hit(ex.rs2_addr, ex.rs2_used, wb);
      lu  = (p_fwd[d] != 0) ? (ld && (h1m || h2m)) : (h1m || h1w || h2m || h2w);
      req = ld && mem.memRead2 && !mem_ready;
      e.to = m_to[d];
      e.sc = 16'(m_sc[d]);
      e.fc = 16'(m_fc[d]);
      n_wait[d] = m_wait[d];
      n_used[d] = m_used[d];
      n_to[d]   = 1'b0;
      n_sc[d]   = m_sc[d];
      n_fc[d]   = m_fc[d];
      if (RST) begin
         n_wait[d] = 1'b0;
         n_used[d] = 0;
         n_sc[d]   = 0;
         n_fc[d]   = 0;
      end else begin
         free = 1'b0;
         hold = 1'b0;
         if (!m_wait[d]) begin
            if (req) begin hold = 1'b1; n_wait[d] = 1'b1; n_used[d] = 1; end
            else free = 1'b1;
         end else if (mem_ready) begin
            n_wait[d] = 1'b0; free = 1'b1;
         end else if (m_used[d] >= p_maxw[d]) begin
            n_wait[d] = 1'b0; n_to[d] = 1'b1;
         end else begin
            hold = 1'b1; n_used[d] = m_used[d] + 1;
         end
         if (hold) e.st = 4'b1111;
         else if (free && lu) begin e.st = 4'b1110; e.fl = 3'b001; end
         else if (free && br_taken) e.fl = 3'b110;
         e.f1 = pick(p_fwd[d] != 0, h1m, ld, h1w);
         e.f2 = pick(p_fwd[d] != 0, h2m, ld, h2w);
         if (clr_cnt) begin
            n_sc[d] = 0; n_fc[d] = 0;
         end else begin
            if (e.st[3] && m_sc[d] < p_cmax[d]) n_sc[d] = m_sc[d] + 1;
            if (e.fl[2] && m_fc[d] < p_cmax[d]) n_fc[d] = m_fc[d] + 1;
         end
      end
   endtask

   task automatic tick();
      obs_t ea, eb;
      model_step(0, ea);
      model_step(1, eb);
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
      @(posedge CLK);
      m_wait = n_wait; m_used = n_used; m_to = n_to; m_sc = n_sc; m_fc = n_fc;
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic compare(input string tag, input obs_t act, input obs_t e);
      chk({tag, ".fwd_sel1"}, 16'(act.f1), 16'(e.f1));
      chk({tag, ".fwd_sel2"}, 16'(act.f2), 16'(e.f2));
      chk({tag, ".stalls"}, 16'(act.st), 16'(e.st));
      chk({tag, ".flushes"}, 16'(act.fl), 16'(e.fl));
      chk({tag, ".mem_timeout"}, 16'(act.to), 16'(e.to));
      chk({tag, ".stall_count"}, act.sc, e.sc);
      chk({tag, ".flush_count"}, act.fc, e.fc);
   endtask

   // Monitor: compare whatever the stimulus side predicted for this cycle
   always @(negedge CLK) begin
      if (exp_a_q.size() > 0) compare("a", obs_a, exp_a_q.pop_front());
      if (exp_b_q.size() > 0) compare("b", obs_b, exp_b_q.pop_front());
   end

   function automatic instr_t mk(input opcode_t op, input int r1, input bit u1, input int r2,
                                 input bit u2, input int rd, input bit rw, input bit mr2);
      instr_t i;
      i.opcode = op; i.rs1_addr = 5'(r1); i.rs1_used = u1; i.rs2_addr = 5'(r2);
      i.rs2_used = u2; i.rd_addr = 5'(rd); i.regWrite = rw; i.memRead2 = mr2;
      return i;
   endfunction

   function automatic instr_t rnd_instr();
      opcode_t ops [5] = '{LOAD, OP, OP_IMM, STORE, BRANCH};
      opcode_t op;
      op = ops[$urandom_range(4)];
      return mk(op, int'($urandom_range(3)), 1'($urandom_range(1)), int'($urandom_range(3)),
                1'($urandom_range(1)), int'($urandom_range(3)), 1'($urandom_range(1)),
                (op == LOAD) ? ($urandom_range(3) != 0) : 1'b0);
   endfunction

   initial begin
      instr_t nop, ld7;
      nop = mk(OP_IMM, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      ld7 = mk(LOAD, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1);
      RST = 1'b1; ex = nop; mem = nop; wb = nop;
      br_taken = 1'b0; mem_ready = 1'b1; clr_cnt = 1'b0;
      @(posedge CLK); #1;
      tick(); tick();
      RST = 1'b0;
      // forwarding priority, then x0 destinations
      ex = mk(OP, 5, 1'b1, 6, 1'b1, 9, 1'b1, 1'b0);
      mem = mk(OP, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0);
      wb = mk(OP, 0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0);
      tick();
      ex = mk(OP, 0, 1'b1, 0, 1'b1, 9, 1'b1, 1'b0);
      mem.rd_addr = 5'd0; wb.rd_addr = 5'd0;
      tick();
      // load-use with a competing branch, then the load sits in WB
      ex = mk(OP, 1, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0); mem = ld7; wb = nop; br_taken = 1'b1;
      tick();
      br_taken = 1'b0; mem = nop; wb = ld7;
      tick();
      // memory wait resolved by mem_ready
      ex = nop; mem = ld7; wb = nop; mem_ready = 1'b0;
      tick(); tick();
      mem_ready = 1'b1;
      tick();
      // timeout: never ready
      mem_ready = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      // reset mid-wait
      mem_ready = 1'b1; mem = nop;
      tick();
      mem = ld7; mem_ready = 1'b0;
      tick(); tick();
      RST = 1'b1;
      tick();
      RST = 1'b0; mem = nop; mem_ready = 1'b1;
      tick(); tick();
      // branch alone, then interlock RAW on WB
      br_taken = 1'b1;
      tick();
      br_taken = 1'b0;
      ex = mk(OP, 3, 1'b1, 0, 1'b0, 4, 1'b1, 1'b0);
      wb = mk(OP, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0);
      tick();
      // long stall to saturate the small counters, then clear during a stall
      ex = nop; wb = nop; mem = ld7; mem_ready = 1'b0;
      for (int k = 0; k < 24; k++) tick();
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0; mem = nop; mem_ready = 1'b1;
      tick();
      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         ex = rnd_instr(); mem = rnd_instr(); wb = rnd_instr();
         br_taken  = ($urandom_range(3) == 0);
         mem_ready = ($urandom_range(1) == 0);
         clr_cnt   = ($urandom_range(49) == 0);
         RST       = ($urandom_range(99) == 0);
         tick();
      end
      RST = 1'b0;
      @(negedge CLK); #1;
      chk("queue_drained", 16'(exp_a_q.size() + exp_b_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
